capp_sequencer: RTL

- Command-level controller for the associative cell array: owns the per-word tag register and sequences SEARCH, tag resolution, masked WRITE and READ against it.
- Drives the array's tag, mismatch-line and write-line buses and samples its match and read buses.
- Front end is a valid/ready command port with one response per command.
- Sits between the host or instruction decoder and the cell array.

---
 rtl/capp_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/capp_sequencer.sv
// Command sequencer for the associative cell array: owns the tag register, runs SEARCH/SELECT/WRITE/READ.
// Latency: accept cycle -> EXEC -> RESP, so rsp_valid rises 2 cycles after accept; 3 cycles per command minimum.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready, blocking new commands.
module capp_sequencer #(
    parameter int num_bits  = 32,
    parameter int num_cells = 100
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [2:0]                       cmd_op,
    input  logic [num_bits-1:0]              cmd_comparand,
    input  logic [num_bits-1:0]              cmd_mask,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [num_bits-1:0]              rsp_data,
    output logic                             rsp_hit,
    output logic [$clog2(num_cells+1)-1:0]   rsp_count,
    output logic [num_cells-1:0]             cell_tags,
    output logic [2*num_bits-1:0]            cell_mismatch_lines,
    output logic [2*num_bits-1:0]            cell_write_lines,
    input  logic [num_cells-1:0]             cell_match_lines,
    input  logic [num_bits-1:0]              cell_read_lines
);
    localparam int CW = $clog2(num_cells+1);
    localparam logic [num_cells-1:0] TAG_ONE = {{(num_cells-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_SET_ALL    = 3'd1;
    localparam logic [2:0] OP_CLEAR_ALL  = 3'd2;
    localparam logic [2:0] OP_SEARCH     = 3'd3;
    localparam logic [2:0] OP_SEARCH_AND = 3'd4;
    localparam logic [2:0] OP_SEL_FIRST  = 3'd5;
    localparam logic [2:0] OP_SEL_NEXT   = 3'd6;
    localparam logic [2:0] OP_WR_RD      = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_op;
    logic [num_bits-1:0]   r_comparand;
    logic [num_bits-1:0]   r_mask;
    logic [num_cells-1:0]  r_tags;
    logic [num_cells-1:0]  w_tags_nxt;
    logic [num_bits-1:0]   r_rsp_data;
    logic [num_bits-1:0]   w_rsp_data_nxt;
    logic                  r_rsp_hit;
    logic [CW-1:0]         r_rsp_count;
    logic [CW-1:0]         w_count_nxt;
    logic                  w_exec;
    logic                  w_is_search;
    logic                  w_is_write;

    // Reset gates the buses so a reset landing in EXEC never lets a partial write reach the array.
    assign w_exec      = (r_state == ST_EXEC) && !RST;
    assign w_is_search = (r_op == OP_SEARCH) || (r_op == OP_SEARCH_AND);
    assign w_is_write  = (r_op == OP_WR_RD) && (r_mask != '0);

    assign cell_tags = r_tags;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_count = r_rsp_count;

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = !RST;
                if (cmd_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tag update and read capture applied at the edge closing EXEC.
    always_comb begin
        w_tags_nxt     = r_tags;
        w_rsp_data_nxt = '0;
        case (r_op)
            OP_NOP:        w_tags_nxt = r_tags;
            OP_SET_ALL:    w_tags_nxt = '1;
            OP_CLEAR_ALL:  w_tags_nxt = '0;
            OP_SEARCH:     w_tags_nxt = ~cell_match_lines;
            OP_SEARCH_AND: w_tags_nxt = r_tags & ~cell_match_lines;
            // x & -x isolates the lowest set bit; x & (x-1) clears it. Both yield 0 for empty tags.
            OP_SEL_FIRST:  w_tags_nxt = r_tags & (~r_tags + TAG_ONE);
            OP_SEL_NEXT:   w_tags_nxt = r_tags & (r_tags - TAG_ONE);
            OP_WR_RD:      if (r_mask == '0) w_rsp_data_nxt = cell_read_lines;
            default:       w_tags_nxt = r_tags;
        endcase
    end

    // Popcount of the post-op tag vector.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < num_cells; i++) begin
            w_count_nxt = w_count_nxt + CW'(w_tags_nxt[i]);
        end
    end

    // Array bus encoding: per bit pair, [2j] for a 1 and [2j+1] for a 0; unmasked pairs stay idle.
    always_comb begin
        cell_mismatch_lines = '0;
        cell_write_lines    = '0;
        for (int j = 0; j < num_bits; j++) begin
            if (w_exec && w_is_search && r_mask[j]) begin
                cell_mismatch_lines[2*j]   = r_comparand[j];
                cell_mismatch_lines[2*j+1] = ~r_comparand[j];
            end
            if (w_exec && w_is_write && r_mask[j]) begin
                cell_write_lines[2*j]   = r_comparand[j];
                cell_write_lines[2*j+1] = ~r_comparand[j];
            end
        end
    end

    // State, tag register and response registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_tags      <= '0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_EXEC) begin
                r_tags      <= w_tags_nxt;
                r_rsp_data  <= w_rsp_data_nxt;
                r_rsp_hit   <= |w_tags_nxt;
                r_rsp_count <= w_count_nxt;
            end
        end
    end

    // Command capture on accept; only consumed in EXEC, so no reset value is needed.
    always_ff @(posedge CLK) begin
        if (cmd_valid && cmd_ready) begin
            r_op        <= cmd_op;
            r_comparand <= cmd_comparand;
            r_mask      <= cmd_mask;
        end
    end
endmodule
